tru_serial_ctrl: RTL and testbench

TRU_SERIAL_CTRL -- requirements
Module: tru_serial_ctrl

---
 rtl/tru_pkg.sv | 22 ++
 rtl/tru_2bit.sv | 20 ++
 rtl/tru_serial_ctrl.sv | 142 ++++++++++++++
 tb/tb_tru_serial_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tru_pkg.sv
// Shared definitions for the serial 2-bit-per-cycle subtractor:
// FSM state encodings and the slice-geometry helpers.
package tru_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SLICE_BITS = 2;

  function automatic int slices_per_word(input int w);
    return w / SLICE_BITS;
  endfunction

  // Slice counter never needs fewer than one bit, even for a single slice.
  function automatic int cnt_width(input int w);
    return (slices_per_word(w) > 1) ? $clog2(slices_per_word(w)) : 1;
  endfunction

endpackage

// File: rtl/tru_2bit.sv
// Combinational 2-bit subtractor slice: d = a - b - bi, bo flags a borrow
// out of the slice.
module tru_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       bi,
  output logic [1:0] d,
  output logic       bo
);

  logic [2:0] diff_s;

  // Widen by one bit so the borrow appears as the MSB of the wrapped result.
  always_comb begin
    diff_s = {1'b0, a} - {1'b0, b} - {2'b00, bi};
    d      = diff_s[1:0];
    bo     = diff_s[2];
  end

endmodule

// File: rtl/tru_serial_ctrl.sv
// Serial subtractor D = A - B - bin, two bits per cycle LSB-first through a
// single shared tru_2bit slice, sequenced by an IDLE/RUN/DONE FSM.
module tru_serial_ctrl
  import tru_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         bin,
  output logic [W-1:0] D,
  output logic         bo,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  localparam int             SLICES   = slices_per_word(W);
  localparam int             CW       = cnt_width(W);
  localparam logic [CW-1:0]  LAST_CNT = CW'(SLICES - 1);

  state_e         state_r;
  state_e         state_next_s;
  logic [CW-1:0]  cnt_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           borrow_r;
  logic [1:0]     a_slice_s;
  logic [1:0]     b_slice_s;
  logic [1:0]     slice_d_s;
  logic           slice_bo_s;
  logic [W-1:0]   d_next_s;

  tru_2bit u_slice (
    .a  (a_slice_s),
    .b  (b_slice_s),
    .bi (borrow_r),
    .d  (slice_d_s),
    .bo (slice_bo_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Select the current operand slice from the latched operands.
  always_comb begin
    a_slice_s = 2'b00;
    b_slice_s = 2'b00;
    for (int i = 0; i < SLICES; i++) begin
      a_slice_s = (cnt_r == CW'(i)) ? a_r[SLICE_BITS*i +: SLICE_BITS] : a_slice_s;
      b_slice_s = (cnt_r == CW'(i)) ? b_r[SLICE_BITS*i +: SLICE_BITS] : b_slice_s;
    end
  end

  // Merge the slice result into the difference word at the current position.
  always_comb begin
    d_next_s = D;
    for (int i = 0; i < SLICES; i++) begin
      d_next_s[SLICE_BITS*i +: SLICE_BITS] =
        (cnt_r == CW'(i)) ? slice_d_s : D[SLICE_BITS*i +: SLICE_BITS];
    end
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      borrow_r <= 1'b0;
      D        <= {W{1'b0}};
      bo       <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_next_s == ST_RUN);
      done <= (state_next_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r      <= A;
            b_r      <= B;
            borrow_r <= bin;
            cnt_r    <= {CW{1'b0}};
            D        <= {W{1'b0}};
          end
        end
        ST_RUN: begin
          D        <= d_next_s;
          borrow_r <= slice_bo_s;
          // Counter parks on the last slice rather than wrapping.
          if (cnt_r == LAST_CNT) begin
            bo   <= slice_bo_s;
            zero <= (d_next_s == {W{1'b0}});
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          cnt_r <= {CW{1'b0}};
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tru_serial_ctrl.sv
// Self-checking bench for tru_serial_ctrl (W=8): directed vector table,
// hand-written start-ignore and reset-abort sequences, and random operands.
module tb_tru_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         bin;
  logic [W-1:0] D;
  logic         bo;
  logic         zero;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  tru_serial_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .D     (D),
    .bo    (bo),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] exp_d;
    logic       exp_bo;
    logic       exp_zero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole word.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] d, output logic bor, output logic z);
    int diff;
    diff = int'(a) - int'(b) - int'(bi);
    bor  = (diff < 0);
    d    = 8'((diff + 256) % 256);
    z    = (d == 8'h00);
  endtask

  // Start one operation and follow it to completion, checking timing and result.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bi, input logic [7:0] ed, input logic eb,
                       input logic ez, input bit garble);
    int cyc;
    int nbusy;
    logic [7:0] held;
    @(negedge clk);
    A = a; B = b; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (garble) begin
      A = 8'($urandom); B = 8'($urandom); bin = 1'($urandom);
    end
    cyc = 0; nbusy = 0;
    while (!done && cyc < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'd4);
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'd4);
    chk({tag, " busy_with_done"}, 32'(busy), 32'd0);
    chk({tag, " D"}, 32'(D), 32'(ed));
    chk({tag, " bo"}, 32'(bo), 32'(eb));
    chk({tag, " zero"}, 32'(zero), 32'(ez));
    held = D;
    @(negedge clk);
    chk({tag, " done_pulse_width"}, 32'(done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " hold_D"}, 32'(D), 32'(held));
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ed;
    logic       eb;
    logic       ez;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbi;
    int         ndone;
    int         nbusy;

    vecs.push_back('{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0});
    vecs.push_back('{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h33, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});

    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset D", 32'(D), 32'd0);
    chk("reset bo", 32'(bo), 32'd0);
    chk("reset zero", 32'(zero), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi,
            vecs[i].exp_d, vecs[i].exp_bo, vecs[i].exp_zero, 1'b1);
    end

    // Second start during RUN must be ignored.
    @(negedge clk);
    A = 8'h5A; B = 8'h23; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'hFF; B = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 2;
    for (int c = 0; c < 12; c++) begin
      if (done) begin
        ndone++;
        chk("ignore_start D", 32'(D), 32'h37);
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
    chk("ignore_start done_count", 32'(ndone), 32'd1);
    chk("ignore_start busy_cycles", 32'(nbusy), 32'd4);

    // Reset in the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    A = 8'h5A; B = 8'h23; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort D", 32'(D), 32'd0);
    chk("abort bo", 32'(bo), 32'd0);
    chk("abort zero", 32'(zero), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("abort no_activity", 32'(ndone), 32'd0);
    do_op("after_abort", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0);

    // Random operands against the arithmetic model, with idle gaps.
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      model(ra, rb, rbi, ed, eb, ez);
      do_op($sformatf("rand%0d", n), ra, rb, rbi, ed, eb, ez, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk($sformatf("rand%0d idle_hold_D", n), 32'(D), 32'(ed));
      chk($sformatf("rand%0d idle_hold_bo", n), 32'(bo), 32'(eb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
